// File: rtl/ddr_arb_pkg.sv
// Shared constants, state and requester encodings for the MCB port-0 arbiter.
package ddr_arb_pkg;

  localparam logic [2:0] CMD_WR     = 3'b000;
  localparam logic [2:0] CMD_RD     = 3'b001;
  localparam int         MAX_BL_DEF = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef enum logic {
    REQ_RD = 1'b0,
    REQ_WR = 1'b1
  } req_id_t;

  // A burst length the MCB cannot encode: zero or longer than the port allows.
  function automatic logic len_bad(input logic [6:0] len, input int max_bl);
    return (len == 7'd0) || (int'(len) > max_bl);
  endfunction

endpackage

// File: rtl/ddr_arb_pick.sv
// Combinational priority: display reads win unless a write has waited out MAX_RD_RUN reads.
module ddr_arb_pick
  import ddr_arb_pkg::*;
#(
  parameter int MAX_RD_RUN = 4,
  parameter int RUN_W      = 3
) (
  input  logic             rd_elig,
  input  logic             wr_elig,
  input  logic [RUN_W-1:0] rd_run,
  output logic             grant,
  output req_id_t          winner
);

  always_comb begin
    grant  = rd_elig | wr_elig;
    winner = REQ_RD;
    if (wr_elig && (!rd_elig || (rd_run == RUN_W'(MAX_RD_RUN))))
      winner = REQ_WR;
  end

endmodule

// File: rtl/ddr_port_arbiter.sv
// Shares the MCB c3_p0 command port between the VGA read fetcher and the SD write loader.
module ddr_port_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int ADDR_W     = 24,
  parameter int MAX_RD_RUN = 4,
  parameter int MAX_BL     = MAX_BL_DEF
) (
  input  logic              c3_clk0,
  input  logic              c3_rst0,
  input  logic              calib_done,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [6:0]        rd_len,
  output logic              rd_ack,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [6:0]        wr_len,
  output logic              wr_ack,
  output logic              c3_p0_cmd_en,
  output logic [2:0]        c3_p0_cmd_instr,
  output logic [5:0]        c3_p0_cmd_bl,
  output logic [29:0]       c3_p0_cmd_byte_addr,
  input  logic              c3_p0_cmd_full,
  input  logic [6:0]        c3_p0_wr_count,
  input  logic              c3_p0_wr_underrun,
  input  logic              c3_p0_rd_overflow,
  output logic              busy,
  output logic [2:0]        err_sticky
);

  localparam int RUN_W = $clog2(MAX_RD_RUN + 1);

  state_t           state_reg, state_next;
  logic [RUN_W-1:0] run_reg;
  req_id_t          id_reg;
  logic             bad_reg;
  logic [2:0]       instr_reg;
  logic [5:0]       bl_reg;
  logic [29:0]      addr_reg;
  logic [2:0]       err_reg;

  logic             rd_bad, wr_bad, rd_elig, wr_elig;
  logic             grant, take, strobe;
  req_id_t          winner;
  logic [6:0]       win_len;
  logic [ADDR_W-1:0] win_addr;
  logic             win_bad;
  logic [29:0]      win_byte;

  // A bad-length write skips the FIFO-fill check so it can be acked and flagged.
  always_comb begin
    rd_bad  = len_bad(rd_len, MAX_BL);
    wr_bad  = len_bad(wr_len, MAX_BL);
    rd_elig = calib_done & rd_req;
    wr_elig = calib_done & wr_req & (wr_bad | (c3_p0_wr_count >= wr_len));
  end

  ddr_arb_pick #(
    .MAX_RD_RUN (MAX_RD_RUN),
    .RUN_W      (RUN_W)
  ) u_pick (
    .rd_elig (rd_elig),
    .wr_elig (wr_elig),
    .rd_run  (run_reg),
    .grant   (grant),
    .winner  (winner)
  );

  always_comb begin
    win_len  = (winner == REQ_WR) ? wr_len  : rd_len;
    win_addr = (winner == REQ_WR) ? wr_addr : rd_addr;
    win_bad  = (winner == REQ_WR) ? wr_bad  : rd_bad;
    win_byte = '0;
    win_byte[ADDR_W+3:4] = win_addr;
  end

  assign take   = (state_reg == IDLE) & grant;
  assign strobe = (state_reg == ISSUE) & ~c3_p0_cmd_full;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant)  state_next = ISSUE;
      ISSUE:   if (strobe) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge c3_clk0) begin
    if (c3_rst0) begin
      state_reg <= IDLE;
      run_reg   <= '0;
      id_reg    <= REQ_RD;
      bad_reg   <= 1'b0;
      instr_reg <= '0;
      bl_reg    <= '0;
      addr_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (take) begin
        id_reg    <= winner;
        bad_reg   <= win_bad;
        instr_reg <= (winner == REQ_WR) ? CMD_WR : CMD_RD;
        bl_reg    <= 6'(win_len - 7'd1);
        addr_reg  <= win_byte;
      end
      // The read run only matters while a write is waiting.
      if (state_reg == IDLE) begin
        if (!wr_req || (take && winner == REQ_WR))
          run_reg <= '0;
        else if (take && run_reg != RUN_W'(MAX_RD_RUN))
          run_reg <= run_reg + 1'b1;
      end
      err_reg[0] <= err_reg[0] | c3_p0_wr_underrun;
      err_reg[1] <= err_reg[1] | c3_p0_rd_overflow;
      err_reg[2] <= err_reg[2] | (take & win_bad);
    end
  end

  assign c3_p0_cmd_en        = strobe & ~bad_reg;
  assign rd_ack              = strobe & (id_reg == REQ_RD);
  assign wr_ack              = strobe & (id_reg == REQ_WR);
  assign c3_p0_cmd_instr     = instr_reg;
  assign c3_p0_cmd_bl        = bl_reg;
  assign c3_p0_cmd_byte_addr = addr_reg;
  assign busy                = (state_reg != IDLE);
  assign err_sticky          = err_reg;

endmodule

// File: tb/tb_ddr_port_arbiter.sv
// Directed bench for ddr_port_arbiter: inputs driven and outputs checked on the falling edge.
module tb_ddr_port_arbiter;

  logic        c3_clk0 = 1'b0;
  logic        c3_rst0;
  logic        calib_done;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic [6:0]  rd_len;
  logic        rd_ack;
  logic        wr_req;
  logic [23:0] wr_addr;
  logic [6:0]  wr_len;
  logic        wr_ack;
  logic        c3_p0_cmd_en;
  logic [2:0]  c3_p0_cmd_instr;
  logic [5:0]  c3_p0_cmd_bl;
  logic [29:0] c3_p0_cmd_byte_addr;
  logic        c3_p0_cmd_full;
  logic [6:0]  c3_p0_wr_count;
  logic        c3_p0_wr_underrun;
  logic        c3_p0_rd_overflow;
  logic        busy;
  logic [2:0]  err_sticky;

  int errors = 0;
  int checks = 0;

  always #5 c3_clk0 = ~c3_clk0;

  ddr_port_arbiter #(.ADDR_W(24), .MAX_RD_RUN(4), .MAX_BL(64)) dut (
    .c3_clk0             (c3_clk0),
    .c3_rst0             (c3_rst0),
    .calib_done          (calib_done),
    .rd_req              (rd_req),
    .rd_addr             (rd_addr),
    .rd_len              (rd_len),
    .rd_ack              (rd_ack),
    .wr_req              (wr_req),
    .wr_addr             (wr_addr),
    .wr_len              (wr_len),
    .wr_ack              (wr_ack),
    .c3_p0_cmd_en        (c3_p0_cmd_en),
    .c3_p0_cmd_instr     (c3_p0_cmd_instr),
    .c3_p0_cmd_bl        (c3_p0_cmd_bl),
    .c3_p0_cmd_byte_addr (c3_p0_cmd_byte_addr),
    .c3_p0_cmd_full      (c3_p0_cmd_full),
    .c3_p0_wr_count      (c3_p0_wr_count),
    .c3_p0_wr_underrun   (c3_p0_wr_underrun),
    .c3_p0_rd_overflow   (c3_p0_rd_overflow),
    .busy                (busy),
    .err_sticky          (err_sticky)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge c3_clk0);
  endtask

  task automatic test_reset();
    c3_rst0 = 1'b1; calib_done = 1'b1;
    rd_req = 0; rd_addr = '0; rd_len = '0;
    wr_req = 0; wr_addr = '0; wr_len = '0;
    c3_p0_cmd_full = 0; c3_p0_wr_count = '0;
    c3_p0_wr_underrun = 0; c3_p0_rd_overflow = 0;
    cyc(3);
    checks++;
    if ({c3_p0_cmd_en, rd_ack, wr_ack, busy} !== 4'b0 || c3_p0_cmd_instr !== 3'b0 ||
        c3_p0_cmd_bl !== 6'd0 || c3_p0_cmd_byte_addr !== 30'd0 || err_sticky !== 3'b0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b rack=%b wack=%b busy=%b instr=%h bl=%0d addr=%h err=%b, want all 0",
               c3_p0_cmd_en, rd_ack, wr_ack, busy, c3_p0_cmd_instr, c3_p0_cmd_bl,
               c3_p0_cmd_byte_addr, err_sticky);
    end
    c3_rst0 = 1'b0;
    cyc(1);
    $display("test_reset done");
  endtask

  task automatic test_read_only();
    rd_req = 1; rd_addr = 24'h000100; rd_len = 7'd32;
    cyc(1);
    checks++;
    if (c3_p0_cmd_en !== 1'b1 || rd_ack !== 1'b1 || wr_ack !== 1'b0 || c3_p0_cmd_instr !== 3'b001 ||
        c3_p0_cmd_bl !== 6'd31 || c3_p0_cmd_byte_addr !== 30'h0001000) begin
      errors++;
      $display("FAIL read_issue: en=%b rack=%b wack=%b instr=%b bl=%0d addr=%h, want 1 1 0 001 31 0001000",
               c3_p0_cmd_en, rd_ack, wr_ack, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr);
    end
    rd_req = 0;
    cyc(1);
    checks++;
    if (rd_ack !== 1'b0 || c3_p0_cmd_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_gap: rack=%b en=%b busy=%b, want 0 0 1", rd_ack, c3_p0_cmd_en, busy);
    end
    cyc(1);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read_back_idle: busy=%b, want 0", busy);
    end
    $display("test_read_only: instr=%b bl=%0d addr=%h", c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr);
  endtask

  task automatic test_write_gating();
    wr_req = 1; wr_addr = 24'h000200; wr_len = 7'd16; c3_p0_wr_count = 7'd10;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      checks++;
      if (c3_p0_cmd_en !== 1'b0 || wr_ack !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL write_gated[%0d]: en=%b wack=%b busy=%b, want 0 0 0", i, c3_p0_cmd_en, wr_ack, busy);
      end
    end
    c3_p0_wr_count = 7'd16;
    cyc(1);
    checks++;
    if (c3_p0_cmd_en !== 1'b1 || wr_ack !== 1'b1 || rd_ack !== 1'b0 || c3_p0_cmd_instr !== 3'b000 ||
        c3_p0_cmd_bl !== 6'd15 || c3_p0_cmd_byte_addr !== 30'h0002000) begin
      errors++;
      $display("FAIL write_issue: en=%b wack=%b rack=%b instr=%b bl=%0d addr=%h, want 1 1 0 000 15 0002000",
               c3_p0_cmd_en, wr_ack, rd_ack, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr);
    end
    wr_req = 0;
    cyc(3);
    $display("test_write_gating done");
  endtask

  task automatic test_anti_starvation();
    string exp_order;
    string got;
    int    wait_cyc;
    exp_order = "RRRRWRRRRW";
    rd_req = 1; rd_addr = 24'h000040; rd_len = 7'd8;
    wr_req = 1; wr_addr = 24'h000080; wr_len = 7'd8; c3_p0_wr_count = 7'd64;
    for (int g = 0; g < 10; g++) begin
      wait_cyc = 0;
      do begin
        cyc(1);
        wait_cyc++;
      end while (!rd_ack && !wr_ack && wait_cyc < 8);
      got = (rd_ack && wr_ack) ? "B" : rd_ack ? "R" : wr_ack ? "W" : "-";
      checks++;
      if (got != exp_order.substr(g, g)) begin
        errors++;
        $display("FAIL grant_order[%0d]: got %s, want %s", g, got, exp_order.substr(g, g));
      end else begin
        $display("grant %0d: %s", g, got);
      end
    end
    rd_req = 0; wr_req = 0;
    cyc(3);
  endtask

  task automatic test_backpressure();
    rd_req = 1; rd_addr = 24'h00ABCD; rd_len = 7'd64; c3_p0_cmd_full = 1;
    cyc(1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (c3_p0_cmd_en !== 1'b0 || rd_ack !== 1'b0 || busy !== 1'b1 || c3_p0_cmd_instr !== 3'b001 ||
          c3_p0_cmd_bl !== 6'd63 || c3_p0_cmd_byte_addr !== 30'h00ABCD0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: en=%b rack=%b busy=%b instr=%b bl=%0d addr=%h, want 0 0 1 001 63 00abcd0",
                 i, c3_p0_cmd_en, rd_ack, busy, c3_p0_cmd_instr, c3_p0_cmd_bl, c3_p0_cmd_byte_addr);
      end
      cyc(1);
    end
    c3_p0_cmd_full = 0;
    #1;
    checks++;
    if (c3_p0_cmd_en !== 1'b1 || rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: en=%b rack=%b, want 1 1", c3_p0_cmd_en, rd_ack);
    end
    rd_req = 0;
    cyc(1);
    checks++;
    if (c3_p0_cmd_en !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_gap: en=%b busy=%b, want 0 1", c3_p0_cmd_en, busy);
    end
    cyc(2);
    $display("test_backpressure done");
  endtask

  task automatic test_bad_length();
    rd_req = 1; rd_addr = 24'h000010; rd_len = 7'd0;
    cyc(1);
    checks++;
    if (rd_ack !== 1'b1 || c3_p0_cmd_en !== 1'b0 || err_sticky !== 3'b100) begin
      errors++;
      $display("FAIL bad_len_issue: rack=%b en=%b err=%b, want 1 0 100", rd_ack, c3_p0_cmd_en, err_sticky);
    end
    rd_req = 0;
    cyc(2);
    c3_p0_wr_underrun = 1;
    cyc(1);
    c3_p0_wr_underrun = 0;
    checks++;
    if (err_sticky !== 3'b101) begin
      errors++;
      $display("FAIL underrun_set: err=%b, want 101", err_sticky);
    end
    cyc(4);
    checks++;
    if (err_sticky !== 3'b101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_held: err=%b busy=%b, want 101 0", err_sticky, busy);
    end
    $display("test_bad_length: err=%b", err_sticky);
  endtask

  task automatic test_reset_mid_issue();
    rd_req = 1; rd_addr = 24'h000300; rd_len = 7'd8; c3_p0_cmd_full = 1;
    cyc(1);
    checks++;
    if (busy !== 1'b1 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL mid_issue_entry: busy=%b rack=%b, want 1 0", busy, rd_ack);
    end
    c3_rst0 = 1; calib_done = 0;
    cyc(1);
    c3_p0_cmd_full = 0;
    #1;
    checks++;
    if ({c3_p0_cmd_en, rd_ack, wr_ack, busy} !== 4'b0 || c3_p0_cmd_instr !== 3'b0 ||
        c3_p0_cmd_bl !== 6'd0 || c3_p0_cmd_byte_addr !== 30'd0 || err_sticky !== 3'b0) begin
      errors++;
      $display("FAIL mid_issue_reset: en=%b rack=%b wack=%b busy=%b instr=%h bl=%0d addr=%h err=%b, want all 0",
               c3_p0_cmd_en, rd_ack, wr_ack, busy, c3_p0_cmd_instr, c3_p0_cmd_bl,
               c3_p0_cmd_byte_addr, err_sticky);
    end
    c3_rst0 = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      checks++;
      if (rd_ack !== 1'b0 || busy !== 1'b0 || c3_p0_cmd_en !== 1'b0) begin
        errors++;
        $display("FAIL no_calib_grant[%0d]: rack=%b busy=%b en=%b, want 0 0 0", i, rd_ack, busy, c3_p0_cmd_en);
      end
    end
    calib_done = 1;
    cyc(1);
    checks++;
    if (rd_ack !== 1'b1 || c3_p0_cmd_en !== 1'b1 || c3_p0_cmd_byte_addr !== 30'h0003000) begin
      errors++;
      $display("FAIL calib_grant: rack=%b en=%b addr=%h, want 1 1 0003000", rd_ack, c3_p0_cmd_en, c3_p0_cmd_byte_addr);
    end
    rd_req = 0;
    cyc(3);
    $display("test_reset_mid_issue done");
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_write_gating();
    test_anti_starvation();
    test_backpressure();
    test_bad_length();
    test_reset_mid_issue();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
